pcmplay_ram_arbiter: RTL and testbench
======================================

PCMPLAY_RAM_ARBITER -- requirements
Module: pcmplay_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning RAM word-address width (4096 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; byteenable width BE_W = DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port freeze  input  1  when high, no new grants are issued.
REQ-006 SHALL have ports mN_address  input  ADDR_W  requester N word address (N = 0, 1).
REQ-007 SHALL have ports mN_read, mN_write  input  1 each  requester N read and write strobes.
REQ-008 SHALL have ports mN_writedata  input  DATA_W, and mN_byteenable  input  BE_W  requester N write data and byte lanes.
REQ-009 SHALL have ports mN_waitrequest  output  1  requester N stall.
REQ-010 SHALL have ports mN_readdata  output  DATA_W, and mN_readdatavalid  output  1  requester N read return.
REQ-011 SHALL have ports ram_address  output  ADDR_W, ram_byteenable  output  BE_W, ram_writedata  output  DATA_W, ram_chipselect  output  1, ram_write  output  1, ram_clken  output  1  single-port RAM drive.
REQ-012 SHALL have port ram_readdata  input  DATA_W  RAM output; address registered in RAM, output unregistered, so read latency is 1.

Function
REQ-013 SHALL issue at most one grant per cycle; requester N requests when mN_read or mN_write is high.
REQ-014 SHALL drive mN_waitrequest low only in the cycle requester N is granted, combinationally from the requests; all other cycles high.
REQ-015 SHALL route the granted requester's address, byteenable, and writedata to ram_*, with ram_chipselect=1 and ram_write=mN_write; without a grant, ram_chipselect=0 and ram_write=0.
REQ-016 SHALL hold ram_clken=1 at all times, including during freeze.
REQ-017 SHALL, for a read accepted in cycle T, assert mN_readdatavalid for exactly cycle T+1 with mN_readdata=ram_readdata; back-to-back reads from either requester are allowed.
REQ-018 SHALL commit a write accepted in cycle T at the clock edge that ends T; no readdatavalid follows.
REQ-019 SHALL treat mN_read and mN_write both high as a write; no readdatavalid follows.
REQ-020 SHALL keep a last_grant register updated on every grant.
REQ-021 SHALL, when both requesters request, grant the one not equal to last_grant.
REQ-022 SHALL, when freeze is high, grant nothing; a read accepted the cycle before freeze still returns at T+1.
REQ-023 SHALL allow a new grant in the same cycle a previous read's readdatavalid is asserted.
REQ-024 SHALL drive mN_readdata from ram_readdata regardless of valid.

Reset
REQ-025 SHALL, while reset_n is low, set last_grant=1 (m0 wins first contention) and clear both read-valid pipeline flags.
REQ-026 SHALL, while reset_n is low, hold mN_readdatavalid=0 and ram_chipselect=0.
REQ-027 SHALL drop any read in flight when reset asserts mid-operation; no readdatavalid is emitted after reset release.
REQ-028 SHALL require reset_n deassertion synchronous to clk.

Configuration
REQ-029 SHALL, with PCMPLAY_ARB_ROUNDROBIN_EN defined, arbitrate per REQ-021.
REQ-030 SHALL, without PCMPLAY_ARB_ROUNDROBIN_EN, use fixed priority: m0 always wins contention; last_grant is still maintained but unused.

Verification
REQ-031 SHALL cover: reset, m0 writes 0xDEADBEEF to 0x010 with byteenable 0xF -> m0_waitrequest=0 in that cycle; m0 reads 0x010 -> m0_readdatavalid 1 cycle later with data 0xDEADBEEF.
REQ-032 SHALL cover: m0 and m1 both read continuously with round-robin -> grants alternate m0,m1,m0,m1; each readdatavalid lands on the correct port at T+1.
REQ-033 SHALL cover: same contention as REQ-032 with the macro undefined -> m0 granted every cycle and m1_waitrequest stays 1.
REQ-034 SHALL cover: m1 writes 0x000000AA to 0xFFF with byteenable 0x1 over existing 0x11223344 -> read returns 0x112233AA, and the address wraps nowhere.
REQ-035 SHALL cover: freeze raised the cycle after an m0 read grant -> m0_readdatavalid still asserts once, then no grants until freeze falls.
REQ-036 SHALL cover: reset_n pulsed low the cycle after a read grant -> no readdatavalid, and m0 wins the first post-reset contention.

Source files
------------

// File: rtl/pcmplay_ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with 1-cycle read latency.
// Define PCMPLAY_ARB_ROUNDROBIN_EN for round-robin; default is fixed m0 priority.
module pcmplay_ram_arbiter #(
    parameter  int ADDR_W = 12,
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic req0, req1;
    logic gnt0, gnt1;
    logic last_grant_q, last_grant_d;
    logic rv0_q, rv0_d;
    logic rv1_q, rv1_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grants are gated by reset_n so nothing reaches the RAM while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !freeze) begin
            if (req0 && req1) begin
`ifdef PCMPLAY_ARB_ROUNDROBIN_EN
                gnt0 = last_grant_q;
`else
                gnt0 = 1'b1;
`endif
                gnt1 = !gnt0;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0) begin
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
        end
    end

    // Read-with-write counts as a write, so no return is scheduled.
    assign rv0_d = gnt0 & m0_read & ~m0_write;
    assign rv1_d = gnt1 & m1_read & ~m1_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rv0_q        <= rv0_d;
            rv1_q        <= rv1_d;
        end
    end

    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        if (gnt0) begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_writedata  = m0_writedata;
            ram_chipselect = 1'b1;
            ram_write      = m0_write;
        end else if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            ram_chipselect = 1'b1;
            ram_write      = m1_write;
        end
    end

    assign ram_clken        = 1'b1;
    assign m0_waitrequest   = ~gnt0;
    assign m1_waitrequest   = ~gnt1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rv0_q;
    assign m1_readdatavalid = rv1_q;

endmodule

// File: tb/tb_pcmplay_ram_arbiter.sv
// Scoreboard bench for pcmplay_ram_arbiter with a behavioural RAM and
// arbitration model; follows PCMPLAY_ARB_ROUNDROBIN_EN like the design.
module tb_pcmplay_ram_arbiter;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        freeze = 1'b0;
    logic [11:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0;
    logic        m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_readdata;

    pcmplay_ram_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered address, unregistered output.
    logic [31:0] mem [4096];
    logic [11:0] raddr = '0;
    assign ram_readdata = mem[raddr];

    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b])
                        mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                raddr <= ram_address;
            end
        end
    end

    logic [31:0] ref_mem [4096];
    exp_t q0[$], q1[$];
    int   lg = 1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic rst_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        int   n;
        n = (p == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            if (p == 0) e = q0[0];
            else        e = q1[0];
        end
        if (v) begin
            checks++;
            if (n == 0) begin
                failures++;
                $display("FAIL rdv%0d_unexpected cyc=%0d actual=1 required=0", p, cyc);
            end else begin
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                if (e.due != cyc || d !== e.data) begin
                    failures++;
                    $display("FAIL rdv%0d_data cyc=%0d actual=%h required=%h due=%0d",
                             p, cyc, d, e.data, e.due);
                end
            end
        end else if (n > 0 && e.due <= cyc) begin
            checks++;
            failures++;
            $display("FAIL rdv%0d_missing cyc=%0d actual=0 required=1", p, cyc);
            if (p == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, m0_readdatavalid, m0_readdata);
        mon(1, m1_readdatavalid, m1_readdata);
    end

    task automatic ref_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic drive(
        input logic r0, input logic w0, input logic [11:0] a0,
        input logic [31:0] d0, input logic [3:0] be0,
        input logic r1, input logic w1, input logic [11:0] a1,
        input logic [31:0] d1, input logic [3:0] be1,
        input logic frz);
        int   g;
        logic rq0, rq1;
        @(negedge clk);
        reset_n = rst_req;
        m0_read = r0; m0_write = w0; m0_address = a0;
        m0_writedata = d0; m0_byteenable = be0;
        m1_read = r1; m1_write = w1; m1_address = a1;
        m1_writedata = d1; m1_byteenable = be1;
        freeze = frz;
        #1;
        rq0 = r0 | w0;
        rq1 = r1 | w1;
        g = -1;
        if (rst_req && !frz) begin
            if (rq0 && rq1) begin
`ifdef PCMPLAY_ARB_ROUNDROBIN_EN
                g = (lg == 0) ? 1 : 0;
`else
                g = 0;
`endif
            end else if (rq0) g = 0;
            else if (rq1)     g = 1;
        end
        chk("wait0", 32'(m0_waitrequest), 32'(g != 0));
        chk("wait1", 32'(m1_waitrequest), 32'(g != 1));
        chk("chipselect", 32'(ram_chipselect), 32'(g >= 0));
        chk("clken", 32'(ram_clken), 32'd1);
        chk("ram_write", 32'(ram_write),
            32'((g == 0 && w0) || (g == 1 && w1)));
        if (g == 0) begin
            chk("addr0", 32'(ram_address), 32'(a0));
            if (w0) ref_write(a0, d0, be0);
            else    q0.push_back('{ref_mem[a0], cyc + 1});
            lg = 0;
        end else if (g == 1) begin
            chk("addr1", 32'(ram_address), 32'(a1));
            if (w1) ref_write(a1, d1, be1);
            else    q1.push_back('{ref_mem[a1], cyc + 1});
            lg = 1;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic both_read(input logic frz);
        drive(1, 0, 12'h010, 0, 0, 1, 0, 12'hFFF, 0, 0, frz);
    endtask

    initial begin
        logic [11:0] a0, a1;
        int          op0, op1;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst_req = 1'b0;
        repeat (3) both_read(0);
        rst_req = 1'b1;
        idle();

        drive(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        drive(0, 0, 0, 0, 0, 0, 1, 12'hFFF, 32'h11223344, 4'hF, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 12'hFFF, 32'h000000AA, 4'h1, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 12'hFFF, 0, 0, 0);
        drive(1, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 12'h020, 32'h55, 4'hF, 0, 0, 0, 0, 0, 0);
        idle();

        repeat (8) both_read(0);
        idle();

        drive(1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) both_read(1);
        both_read(0);
        idle();

        drive(1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rst_req = 1'b0;
        q0.delete();
        q1.delete();
        lg = 1;
        #1;
        chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
        chk("rst_cs", 32'(ram_chipselect), 32'd0);
        repeat (2) both_read(0);
        rst_req = 1'b1;
        both_read(0);
        both_read(0);
        idle();

        for (int i = 0; i < 400; i++) begin
            op0 = $urandom_range(0, 3);
            op1 = $urandom_range(0, 3);
            a0 = ($urandom_range(0, 8) == 8) ? 12'hFFF : 12'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 8) == 8) ? 12'hFFF : 12'($urandom_range(0, 7));
            drive(op0[0], op0[1], a0, $urandom, 4'($urandom),
                  op1[0], op1[1], a1, $urandom, 4'($urandom),
                  $urandom_range(0, 7) == 0);
        end

        repeat (3) idle();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
